// File: rtl/port_seq_pkg.sv
// Shared definitions for the port_seq transfer sequencer: FSM state encoding,
// port direction constants and the default TX FIFO depth.
package port_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        TX_LOAD,
        TX_HOLD,
        RX_CAP,
        RX_READ
    } port_seq_state_e;

    localparam logic PORT_Z_OUT = 1'b1;
    localparam logic PORT_Z_IN  = 1'b0;

    localparam int PORT_SEQ_FIFO_DEPTH = 4;

endpackage

// File: rtl/port_seq_fifo.sv
// Flop-based synchronous TX FIFO for port_seq; pushes into a full FIFO and pops
// from an empty one are ignored. DEPTH must be a power of two, at least 2.
module port_seq_fifo
    import port_seq_pkg::*;
#(
    parameter int DEPTH = PORT_SEQ_FIFO_DEPTH,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/port_seq.sv
// Transfer sequencer for the bidirectional latch port: TX FIFO, RX fetch and ce/z control.
// Define PORT_SEQ_TURN_EN to insert one TURN cycle on every change of port_z.
module port_seq
    import port_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = PORT_SEQ_FIFO_DEPTH,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              rx_req,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              port_ce,
    output logic              port_z,
    inout  wire  [DATA_W-1:0] port_dio,
    output logic              busy
);
    port_seq_state_e   state_q, state_d;
    port_seq_state_e   arb_state;
    logic              arb_z;
    logic              ce_q, ce_d;
    logic              z_q, z_d;
    logic              drive_q, drive_d;
    logic              rx_pend_q, rx_pend_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    assign fifo_push = tx_valid && !fifo_full;
    assign fifo_pop  = (state_q == TX_LOAD);

    port_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (tx_data),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A pending RX wins over TX, but only once the previous RX byte has been taken.
    always_comb begin
        arb_state = IDLE;
        arb_z     = z_q;
        if (rx_pend_q && !rx_valid_q) begin
            arb_state = RX_CAP;
            arb_z     = PORT_Z_IN;
        end else if (!fifo_empty) begin
            arb_state = TX_LOAD;
            arb_z     = PORT_Z_OUT;
        end
    end

    always_comb begin
        case (state_q)
            IDLE, TX_HOLD: state_d = arb_state;
            TURN:          state_d = (z_q == PORT_Z_OUT) ? TX_LOAD : RX_CAP;
            TX_LOAD:       state_d = TX_HOLD;
            RX_CAP:        state_d = RX_READ;
            RX_READ:       state_d = IDLE;
            default:       state_d = IDLE;
        endcase
`ifdef PORT_SEQ_TURN_EN
        if ((state_q == IDLE || state_q == TX_HOLD) && arb_state != IDLE && arb_z != z_q) begin
            state_d = TURN;
        end
`endif

        // Port controls are registered, so they are decoded from the next state.
        case (state_d)
            TURN:             z_d = arb_z;
            TX_LOAD, TX_HOLD: z_d = PORT_Z_OUT;
            RX_CAP, RX_READ:  z_d = PORT_Z_IN;
            default:          z_d = z_q;
        endcase
        ce_d      = (state_d == TX_LOAD) || (state_d == RX_CAP);
        drive_d   = (state_d == TX_LOAD) || (state_d == TX_HOLD);
        tx_byte_d = (state_d == TX_LOAD) ? fifo_head : tx_byte_q;

        rx_pend_d  = rx_pend_q || rx_req;
        rx_valid_d = rx_valid_q && !rx_ready;
        rx_data_d  = rx_data_q;
        if (state_q == RX_READ) begin
            rx_pend_d  = 1'b0;
            rx_valid_d = 1'b1;
            rx_data_d  = port_dio;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ce_q       <= 1'b0;
            z_q        <= PORT_Z_OUT;
            drive_q    <= 1'b0;
            tx_byte_q  <= '0;
            rx_pend_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ce_q       <= ce_d;
            z_q        <= z_d;
            drive_q    <= drive_d;
            tx_byte_q  <= tx_byte_d;
            rx_pend_q  <= rx_pend_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign port_dio = drive_q ? tx_byte_q : {DATA_W{1'bz}};
    assign port_ce  = ce_q;
    assign port_z   = z_q;
    assign tx_ready = !fifo_full;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = (state_q != IDLE) || !fifo_empty || rx_pend_q;

endmodule

// File: tb/tb_port_seq.sv
// Self-checking bench for port_seq: directed TX/RX/priority/reset scenarios, then
// randomized traffic checked against a transaction-level model of the port.
module tb_port_seq;
    import port_seq_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = 8'h00;
    logic       rx_req = 1'b0;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       port_ce;
    logic       port_z;
    wire  [7:0] port_dio;
    logic       busy;

    logic [7:0] far_in = 8'h00;
    logic [7:0] far_latch = 8'h00;

    int n_checks = 0;
    int n_fail = 0;
    int ce_count = 0;
    logic [7:0] tx_log[$];

    bit         mon_en = 1'b0;
    logic [7:0] exp_q[$];
    bit         m_pend = 1'b0;
    bit         m_valid = 1'b0;
    bit         m_in_read = 1'b0;
    bit         m_in_hold = 1'b0;
    logic [7:0] m_rx = 8'h00;
    logic [7:0] m_hold = 8'h00;
    bit         m_ready, m_new_hold, m_new_read, m_valid_next;

    port_seq dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_req   (rx_req),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .port_ce  (port_ce),
        .port_z   (port_z),
        .port_dio (port_dio),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Behavioural latch port: reads back its latch toward us when z=0.
    assign port_dio = (port_z == PORT_Z_IN) ? far_latch : 8'hzz;

    always @(posedge clk) begin
        if (port_ce) far_latch <= (port_z == PORT_Z_OUT) ? port_dio : far_in;
    end

    always @(negedge clk) begin
        if (port_ce) ce_count = ce_count + 1;
        if (port_ce && port_z == PORT_Z_OUT) tx_log.push_back(port_dio);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic req, input logic rdy);
        tx_valid = v;
        tx_data  = d;
        rx_req   = req;
        rx_ready = rdy;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: accepted bytes leave in order, one per ce pulse with z=1;
    // each ce pulse with z=0 captures the far-side byte that later appears on rx_data.
    always @(negedge clk) begin
        if (mon_en) begin
            m_ready = (exp_q.size() < DEPTH);
            checkOutput("rnd_tx_ready", tx_ready, m_ready);
            checkOutput("rnd_rx_valid", rx_valid, m_valid);
            if (m_valid) checkOutput("rnd_rx_data", rx_data, m_rx);
            if (exp_q.size() != 0 || m_pend) checkOutput("rnd_busy", busy, 1);
            if (port_z == PORT_Z_IN) checkOutput("rnd_no_contention", port_dio, far_latch);
            if (m_in_hold) begin
                checkOutput("rnd_hold_z", port_z, PORT_Z_OUT);
                checkOutput("rnd_hold_ce", port_ce, 0);
                checkOutput("rnd_hold_dio", port_dio, m_hold);
                checkOutput("rnd_far_side", far_latch, m_hold);
            end
            if (m_in_read) begin
                checkOutput("rnd_read_ce", port_ce, 0);
                checkOutput("rnd_read_z", port_z, PORT_Z_IN);
            end

            m_new_hold = 1'b0;
            if (port_ce && port_z == PORT_Z_OUT) begin
                checkOutput("rnd_tx_queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    m_hold = exp_q.pop_front();
                    checkOutput("rnd_tx_byte", port_dio, m_hold);
                    m_new_hold = 1'b1;
                end
            end
            if (tx_valid && m_ready) exp_q.push_back(tx_data);

            m_new_read = 1'b0;
            if (port_ce && port_z == PORT_Z_IN) begin
                checkOutput("rnd_cap_pending", m_pend, 1);
                checkOutput("rnd_cap_rx_idle", rx_valid, 0);
                m_rx = far_in;
                m_new_read = 1'b1;
            end
            m_valid_next = m_valid && !rx_ready;
            if (m_in_read) begin
                m_valid_next = 1'b1;
                m_pend = 1'b0;
            end else if (rx_req) begin
                m_pend = 1'b1;
            end
            m_valid   = m_valid_next;
            m_in_hold = m_new_hold;
            m_in_read = m_new_read;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int cap_k;
        int load_k;
        bit found;
        logic [1:8] pce;
        logic [1:8] pz;
        logic [7:0] got;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_tx_ready", tx_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ce", port_ce, 0);
        checkOutput("rst_z", port_z, PORT_Z_OUT);
        checkOutput("rst_rx_valid", rx_valid, 0);
        checkOutput("rst_rx_data", rx_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        nextCycle();

        // Single TX of 0xA5
        $display("[TB] TX path");
        tx_log.delete();
        base = ce_count;
        applyStimulus(1, 8'hA5, 0, 1);
        nextCycle();
        applyStimulus(0, 8'h00, 0, 1);
        @(negedge clk);
        checkOutput("tx_n1_ce", port_ce, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("tx_load_ce", port_ce, 1);
        checkOutput("tx_load_z", port_z, PORT_Z_OUT);
        checkOutput("tx_load_dio", port_dio, 8'hA5);
        nextCycle();
        @(negedge clk);
        checkOutput("tx_hold_ce", port_ce, 0);
        checkOutput("tx_hold_dio", port_dio, 8'hA5);
        checkOutput("tx_far_side", far_latch, 8'hA5);
        checkOutput("tx_hold_busy", busy, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("tx_done_busy", busy, 0);
        checkOutput("tx_done_ce", port_ce, 0);
        repeat (3) nextCycle();
        checkOutput("tx_ce_pulses", ce_count - base, 1);

        // FIFO fill while an RX transfer occupies the FSM
        $display("[TB] FIFO full");
        tx_log.delete();
        applyStimulus(1, 8'h01, 1, 1);
        @(negedge clk);
        checkOutput("full_ready_0", tx_ready, 1);
        for (int i = 2; i <= 4; i++) begin
            nextCycle();
            applyStimulus(1, 8'(i), 0, 1);
            @(negedge clk);
            checkOutput($sformatf("full_ready_%0d", i - 1), tx_ready, 1);
        end
        nextCycle();
        applyStimulus(1, 8'h05, 0, 1);
        @(negedge clk);
        checkOutput("full_ready_4", tx_ready, 0);
        nextCycle();
        applyStimulus(0, 8'h00, 0, 1);
        repeat (20) nextCycle();
        checkOutput("full_tx_count", tx_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            got = (i < tx_log.size()) ? tx_log[i] : 8'h00;
            checkOutput($sformatf("full_order_%0d", i), got, i + 1);
        end

        // RX and TX requested together, starting with port_z=1
        $display("[TB] priority and turnaround");
        tx_log.delete();
`ifdef PORT_SEQ_TURN_EN
        pce = 8'b00100010;
        pz  = 8'b10000111;
        load_k = 7;
`else
        pce = 8'b01001000;
        pz  = 8'b10001111;
        load_k = 5;
`endif
        far_in = 8'h5A;
        applyStimulus(1, 8'h11, 1, 1);
        nextCycle();
        applyStimulus(0, 8'h00, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checkOutput($sformatf("prio_ce_%0d", k), port_ce, pce[k]);
            checkOutput($sformatf("prio_z_%0d", k), port_z, pz[k]);
            if (k == load_k) checkOutput("prio_tx_dio", port_dio, 8'h11);
            nextCycle();
        end
        checkOutput("prio_rx_data", rx_data, 8'h5A);
        checkOutput("prio_tx_count", tx_log.size(), 1);

        // RX of 0x3C, consumer initially stalled
        $display("[TB] RX path");
`ifdef PORT_SEQ_TURN_EN
        cap_k = 3;
`else
        cap_k = 2;
`endif
        far_in = 8'h3C;
        applyStimulus(0, 8'h00, 1, 0);
        nextCycle();
        applyStimulus(0, 8'h00, 0, 0);
        for (int k = 1; k <= cap_k + 3; k++) begin
            @(negedge clk);
            if (port_z == PORT_Z_IN) checkOutput($sformatf("rx_no_drive_%0d", k), port_dio, far_latch);
            if (k == cap_k) begin
                checkOutput("rx_cap_ce", port_ce, 1);
                checkOutput("rx_cap_z", port_z, PORT_Z_IN);
            end
            if (k == cap_k + 1) checkOutput("rx_read_valid", rx_valid, 0);
            if (k == cap_k + 2) begin
                checkOutput("rx_valid_set", rx_valid, 1);
                checkOutput("rx_data", rx_data, 8'h3C);
            end
            if (k == cap_k + 3) checkOutput("rx_valid_held", rx_valid, 1);
            nextCycle();
        end
        applyStimulus(0, 8'h00, 0, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("rx_valid_cleared", rx_valid, 0);
        nextCycle();

        // Reset asserted during TX_LOAD
        $display("[TB] reset mid-TX");
        applyStimulus(1, 8'h77, 0, 1);
        nextCycle();
        applyStimulus(1, 8'h78, 0, 1);
        nextCycle();
        applyStimulus(0, 8'h00, 0, 1);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (port_ce && port_z == PORT_Z_OUT) found = 1'b1;
            else nextCycle();
        end
        checkOutput("rstmid_found_load", found, 1);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_ce", port_ce, 0);
        checkOutput("rstmid_z", port_z, PORT_Z_OUT);
        checkOutput("rstmid_tx_ready", tx_ready, 1);
        checkOutput("rstmid_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        base = ce_count;
        repeat (6) nextCycle();
        checkOutput("rstmid_no_ce", ce_count - base, 0);
        checkOutput("rstmid_busy_after", busy, 0);
        checkOutput("rstmid_ready_after", tx_ready, 1);

        // Randomized traffic against the reference model
        $display("[TB] random traffic");
        mon_en = 1'b1;
        repeat (1500) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                          $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
            far_in = 8'($urandom);
            nextCycle();
        end
        applyStimulus(0, 8'h00, 0, 1);
        for (int k = 0; k < 60 && (busy || rx_valid); k++) nextCycle();
        checkOutput("drain_busy", busy, 0);
        checkOutput("drain_queue", exp_q.size(), 0);
        checkOutput("drain_pend", m_pend, 0);
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
